// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: rotates a one-hot column drive, assembles 12-bit scan
// snapshots, debounces them over several identical scans and reports single-key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] Col,
  input  logic [3:0] Row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEB_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEB_SCANS);

  typedef enum logic [1:0] {StIdle, StPressed, StMulti} state_e;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      col_q, col_d;
  logic [11:0]     snap_q, snap_d;
  logic [11:0]     prev_q, prev_d;
  logic [CntW-1:0] stable_q, stable_d;
  logic [11:0]     pat_q, pat_d;
  logic            upd_q, upd_d;
  state_e          state_q, state_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_release_q, key_release_d;
  logic            key_held_q, key_held_d;
  logic            multi_key_q, multi_key_d;

  logic            tick;
  logic            scan_done;
  logic            pat_single;
  logic [3:0]      pat_idx;

  // Column dwell, row sampling and scan-level debounce
  always_comb begin
    tick      = (div_cnt_q == DivLast);
    scan_done = tick & col_q[2];
    div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
    col_d     = tick ? {col_q[1:0], col_q[2]} : col_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    pat_d     = pat_q;
    upd_d     = 1'b0;
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (col_q[c]) snap_d[3*r+c] = Row[r];
        end
      end
    end
    if (scan_done) begin
      if (snap_d == prev_q) begin
        if (stable_q != CntMax) begin
          stable_d = stable_q + CntW'(1);
          upd_d    = (stable_q + CntW'(1) == CntMax);
        end
      end else begin
        stable_d = CntW'(1);
        prev_d   = snap_d;
      end
    end
    if (upd_d) pat_d = snap_d;
  end

  // Key event FSM, evaluated the cycle after a debounced-pattern update
  always_comb begin
    pat_single = (pat_q != '0) && ((pat_q & (pat_q - 12'd1)) == '0);
    pat_idx    = '0;
    for (int i = 0; i < 12; i++) begin
      if (pat_q[i]) pat_idx = 4'(i);
    end
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    if (upd_q) begin
      unique case (state_q)
        StIdle: begin
          if (pat_single) begin
            state_d     = StPressed;
            key_code_d  = pat_idx;
            key_valid_d = 1'b1;
          end else if (pat_q != '0) begin
            state_d = StMulti;
          end
        end
        StPressed: begin
          if (pat_q == '0) begin
            state_d       = StIdle;
            key_release_d = 1'b1;
          end else if (!pat_single || pat_idx != key_code_q) begin
            // No rollover: any different pattern blocks reporting until all keys lift
            state_d = StMulti;
          end
        end
        StMulti: begin
          if (pat_q == '0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    key_held_d  = (state_d == StPressed);
    multi_key_d = (state_d == StMulti);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      col_q         <= 3'b001;
      snap_q        <= '0;
      prev_q        <= '0;
      stable_q      <= '0;
      pat_q         <= '0;
      upd_q         <= 1'b0;
      state_q       <= StIdle;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      col_q         <= col_d;
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      stable_q      <= stable_d;
      pat_q         <= pat_d;
      upd_q         <= upd_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign Col         = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign key_held    = key_held_q;
  assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model drives Row from a key vector, a scan-history
// model predicts every output each cycle, and directed scenarios pin literal timings.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int SCAN = 3 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid, key_release, key_held, multi_key;
  logic [11:0] keys = '0;

  int total = 0;
  int bad = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Col        (col),
    .Row        (row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_release(key_release),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = |(keys[3*r +: 3] & col);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: cycle index n since reset release, list of completed scans,
  // and the event rules applied one edge after the accepting scan.
  int          n;
  logic [11:0] scan_acc;
  logic [11:0] scans[$];
  int          m_state;  // 0 idle, 1 pressed, 2 multi
  int          m_code;
  bit          m_valid, m_release;
  bit          pend;
  logic [11:0] pend_pat;

  function automatic int first_bit(input logic [11:0] p);
    int idx = 0;
    for (int i = 0; i < 12; i++) if (p[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    n = 0; scan_acc = '0; scans.delete(); m_state = 0; m_code = 0;
    m_valid = 0; m_release = 0; pend = 0; pend_pat = '0;
  endtask

  task automatic model_step();
    int c, run, cnt;
    m_valid = 0; m_release = 0;
    if (pend) begin
      cnt = $countones(pend_pat);
      case (m_state)
        0: if (cnt == 1) begin m_state = 1; m_code = first_bit(pend_pat); m_valid = 1; end
           else if (cnt > 1) m_state = 2;
        1: if (cnt == 0) begin m_state = 0; m_release = 1; end
           else if (!(cnt == 1 && first_bit(pend_pat) == m_code)) m_state = 2;
        default: if (cnt == 0) m_state = 0;
      endcase
      pend = 0;
    end
    c = (n / SD) % 3;
    if (n % SD == SD - 1) begin
      for (int r = 0; r < 4; r++) scan_acc[3*r+c] = keys[3*r+c];
      if (c == 2) begin
        scans.push_back(scan_acc);
        if (scans.size() > DEB + 1) void'(scans.pop_front());
        run = 0;
        for (int i = scans.size() - 1; i >= 0; i--) begin
          if (scans[i] != scan_acc) break;
          run++;
        end
        if (run == DEB) begin pend = 1; pend_pat = scan_acc; end
      end
    end
    n++;
  endtask

  initial begin
    logic [10:0] act, exp;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      act = {col, key_code, key_valid, key_release, key_held, multi_key};
      exp = {3'(1 << ((n / SD) % 3)), 4'(m_code), m_valid, m_release,
             (m_state == 1), (m_state == 2)};
      check("cycle_outputs", int'(act), int'(exp));
      if (rst_n) model_step();
    end
  end

  int nvalid = 0;
  int nrel = 0;
  always @(negedge clk) begin
    if (key_valid) nvalid <= nvalid + 1;
    if (key_release) nrel <= nrel + 1;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_scan_start();
    tick(1);
    while (n % SCAN != 0) tick(1);
  endtask

  task automatic press_only(input int k);
    logic [11:0] m;
    m = '0;
    m[k] = 1'b1;
    keys = m;
  endtask

  initial begin
    int v0, r0, k, sel, found;
    logic [11:0] m;
    // Reset state
    tick(3);
    check("rst_col", int'(col), 1);
    check("rst_outputs", int'({key_code, key_valid, key_release, key_held, multi_key}), 0);

    // Key 7 held from reset release: accepted exactly 37 edges later
    press_only(7);
    v0 = nvalid; r0 = nrel;
    rst_n = 1'b1;
    tick(36);
    check("k7_valid_early", int'(key_valid), 0);
    tick(1);
    check("k7_valid", int'(key_valid), 1);
    check("k7_code", int'(key_code), 7);
    check("k7_held", int'(key_held), 1);
    tick(1);
    check("k7_valid_pulse", int'(key_valid), 0);
    keys = '0;
    tick(5 * SCAN);
    check("k7_valid_count", nvalid - v0, 1);
    check("k7_release_count", nrel - r0, 1);
    check("k7_held_off", int'(key_held), 0);

    // Key 4 bounce for two scans only
    v0 = nvalid; r0 = nrel;
    wait_scan_start();
    press_only(4);
    tick(2 * SCAN);
    keys = '0;
    tick(5 * SCAN);
    check("k4_no_valid", nvalid - v0, 0);
    check("k4_no_release", nrel - r0, 0);
    check("k4_idle", int'({key_held, multi_key}), 0);

    // Keys 0 and 11 together
    v0 = nvalid; r0 = nrel;
    keys = 12'h801;
    tick(5 * SCAN);
    check("k0_11_multi", int'(multi_key), 1);
    keys = 12'h800;
    tick(5 * SCAN);
    check("k11_left_multi", int'(multi_key), 1);
    check("k11_left_no_valid", nvalid - v0, 0);
    keys = '0;
    tick(5 * SCAN);
    check("multi_cleared", int'({key_held, multi_key}), 0);
    check("multi_no_release", nrel - r0, 0);

    // Key 3 accepted, then key 5 added
    v0 = nvalid;
    press_only(3);
    tick(5 * SCAN);
    check("k3_code", int'(key_code), 3);
    keys = 12'h028;
    tick(5 * SCAN);
    check("k3_5_multi", int'(multi_key), 1);
    check("k3_5_code_kept", int'(key_code), 3);
    check("k3_5_valid_count", nvalid - v0, 1);
    keys = '0;
    tick(5 * SCAN);

    // Reset while Col=100 with key 2 accepted
    press_only(2);
    tick(5 * SCAN);
    check("k2_held", int'(key_held), 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (col == 3'b100) found = 1; else tick(1);
    end
    check("k2_col100_seen", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("k2_rst_col", int'(col), 1);
    check("k2_rst_outputs", int'({key_code, key_valid, key_release, key_held, multi_key}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(36);
    check("k2_revalid_early", int'(key_valid), 0);
    tick(1);
    check("k2_revalid", int'(key_valid), 1);
    check("k2_recode", int'(key_code), 2);
    keys = '0;
    tick(5 * SCAN);

    // Every key in turn
    for (int i = 0; i < 12; i++) begin
      v0 = nvalid;
      press_only(i);
      tick(5 * SCAN);
      check("sweep_code", int'(key_code), i);
      check("sweep_valid", nvalid - v0, 1);
      keys = '0;
      tick(5 * SCAN);
    end

    // Randomized presses, bounces and chords
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        k = $urandom_range(0, 11);
        press_only(k);
      end else if (sel == 2) begin
        keys = '0;
      end else begin
        m = 12'($urandom);
        keys = m;
      end
      tick($urandom_range(1, 60));
    end
    keys = '0;
    tick(5 * SCAN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
